// File: rtl/regfile_wrarb_pkg.sv
// regfile_wrarb_pkg: shared regfile widths, zero-register index and write-port select encoding
package regfile_wrarb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {SEL_NONE, SEL_HOLD, SEL_WB, SEL_MD} sel_e;
endpackage

// File: rtl/regfile_wrarb.sv
// regfile_wrarb: shares the regfile write port between pipeline writeback and a held mul/div result
module regfile_wrarb
  import regfile_wrarb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_o,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              regwrite,
  output logic [ADDR_W-1:0] wreg,
  output logic [DATA_W-1:0] wdata
);
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_reg_q, hold_reg_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              accept, drain, wb_hit, capture;
  sel_e              sel;
  always_comb begin
    md_ready = reset && !hold_valid_q;
    accept   = md_valid && md_ready;
    drain    = reset && hold_valid_q && starve_cnt_q == 4'(STARVE_MAX);
    stall_o  = drain;
    sel      = !reset      ? SEL_NONE :
               drain        ? SEL_HOLD :
               wb_we        ? SEL_WB   :
               hold_valid_q ? SEL_HOLD :
               accept       ? SEL_MD   : SEL_NONE;
    wreg     = sel == SEL_HOLD ? hold_reg_q  : sel == SEL_WB ? wb_reg  : sel == SEL_MD ? md_reg  : '0;
    wdata    = sel == SEL_HOLD ? hold_data_q : sel == SEL_WB ? wb_data : sel == SEL_MD ? md_data : '0;
    regwrite = sel != SEL_NONE && wreg != ADDR_W'(REG_ZERO);
    // a younger pipeline write to the held register makes the held value stale
    wb_hit   = sel == SEL_WB && hold_valid_q && wb_reg == hold_reg_q;
    capture  = sel == SEL_WB && accept && md_reg != ADDR_W'(REG_ZERO);
    hold_valid_d = (sel == SEL_HOLD || wb_hit) ? 1'b0 : capture ? 1'b1 : hold_valid_q;
    starve_cnt_d = (sel == SEL_HOLD || wb_hit) ? 4'd0 :
                   (sel == SEL_WB && hold_valid_q) ? starve_cnt_q + 4'd1 : starve_cnt_q;
    hold_reg_d   = capture ? md_reg  : hold_reg_q;
    hold_data_d  = capture ? md_data : hold_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    hold_reg_q  <= hold_reg_d;
    hold_data_q <= hold_data_d;
  end
endmodule
